// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with optional per-requester lock for multi-byte messages and a completion watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter logic [7:0]  MAX_LOCK_BYTES = 8'd16,
  parameter logic [15:0] TIMEOUT_CLKS   = 16'd1000
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Lock,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [ID_W-1:0]      o_Grant_Id,
  output logic                 o_Err
);

  typedef enum logic [2:0] {
    StArb,
    StLaunch,
    StWaitActive,
    StWaitDone,
    StRelease
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]    ptr_q, grant_q;
  logic               lock_q;
  logic [7:0]         lock_cnt_q;
  logic [15:0]        wd_q, wd_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               dv_q, err_q;
  logic [7:0]         byte_q;

  logic [ID_W-1:0] idx, rr_win, win;
  logic            rr_found, owner_hold, can_arb, grant_en, in_wait, abort;

  // Search starts just after the last winner, so a capped lock owner comes last.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr_q;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!rr_found && i_Req_Valid[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

  // Arbitration also runs in RELEASE once Done drops, keeping the frame gap at 4 clocks.
  always_comb begin
    owner_hold = lock_q && i_Req_Valid[grant_q] && (lock_cnt_q < MAX_LOCK_BYTES);
    win        = owner_hold ? grant_q : rr_win;
    can_arb    = (state_q == StArb) || ((state_q == StRelease) && !i_Tx_Done);
    grant_en   = can_arb && (owner_hold || rr_found);
    in_wait    = (state_q == StWaitActive) || (state_q == StWaitDone);
    abort      = in_wait && (wd_q >= TIMEOUT_CLKS - 16'd1);
    ack_d      = '0;
    if (grant_en) begin
      ack_d[win] = 1'b1;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (state_q == StLaunch) begin
      wd_d = '0;
    end else if (in_wait && (wd_q != 16'hFFFF)) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb: begin
        if (grant_en) state_d = StLaunch;
      end
      StLaunch: state_d = StWaitActive;
      StWaitActive: begin
        if (abort) state_d = StArb;
        else if (i_Tx_Active) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (abort) state_d = StArb;
        else if (i_Tx_Done) state_d = StRelease;
      end
      StRelease: begin
        if (grant_en) state_d = StLaunch;
        else if (!i_Tx_Done) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= StArb;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      grant_q    <= '0;
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
      wd_q       <= '0;
      ack_q      <= '0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      byte_q     <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      dv_q    <= (state_q == StLaunch);
      err_q   <= abort;
      if (grant_en) begin
        byte_q     <= i_Req_Byte[{win, 3'b000} +: 8];
        grant_q    <= win;
        ptr_q      <= win;
        lock_q     <= i_Req_Lock[win];
        lock_cnt_q <= owner_hold ? lock_cnt_q + 8'd1 : 8'd1;
      end
    end
  end

  assign o_Req_Ack  = ack_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Busy     = (state_q != StArb);
  assign o_Grant_Id = grant_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: stub transmitter, queue-based requesters,
// grant/DV/error logs compared against hand-computed sequences.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int FRAME = 40;

  logic            i_Clock = 1'b0;
  logic            i_Reset;
  logic [NR-1:0]   i_Req_Valid;
  logic [8*NR-1:0] i_Req_Byte;
  logic [NR-1:0]   i_Req_Lock;
  logic [NR-1:0]   o_Req_Ack;
  logic            o_Tx_DV;
  logic [7:0]      o_Tx_Byte;
  logic            i_Tx_Active;
  logic            i_Tx_Done;
  logic            o_Busy;
  logic [1:0]      o_Grant_Id;
  logic            o_Err;

  uart_tx_arbiter dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Byte  (i_Req_Byte),
    .i_Req_Lock  (i_Req_Lock),
    .o_Req_Ack   (o_Req_Ack),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Busy      (o_Busy),
    .o_Grant_Id  (o_Grant_Id),
    .o_Err       (o_Err)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  // Stub transmitter: Active the cycle after DV, Done high two cycles at frame end.
  logic stub_active = 1'b0;
  logic hang = 1'b0;
  int   stub_cnt = 0;
  int   done_cnt = 0;
  always @(posedge i_Clock) begin
    if (done_cnt != 0) done_cnt <= done_cnt - 1;
    if (o_Tx_DV) begin
      stub_active <= 1'b1;
      stub_cnt    <= 0;
    end else if (stub_active && !hang) begin
      if (stub_cnt == FRAME - 1) begin
        stub_active <= 1'b0;
        done_cnt    <= 2;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end
  assign i_Tx_Active = stub_active;
  assign i_Tx_Done   = (done_cnt != 0);

  int         rem[NR];
  logic [7:0] nxt_byte[NR];
  logic [7:0] step;
  logic [NR-1:0] pulse;
  int         ack_log[$];
  int         dv_cyc[$];
  int         done_cyc[$];
  int         err_cyc[$];
  logic [7:0] dv_byte[$];
  int         viol = 0;
  logic       prev_done = 1'b0;

  // Requester model and monitors share one negedge process so ordering is fixed.
  initial begin
    i_Req_Valid = '0;
    i_Req_Byte  = '0;
    forever begin
      @(negedge i_Clock);
      if ((o_Req_Ack & ~i_Req_Valid) != '0) viol++;
      for (int k = 0; k < NR; k++) if (o_Req_Ack[k]) ack_log.push_back(k);
      if (o_Tx_DV) begin
        dv_cyc.push_back(cyc);
        dv_byte.push_back(o_Tx_Byte);
      end
      if (i_Tx_Done && !prev_done) done_cyc.push_back(cyc);
      prev_done = i_Tx_Done;
      if (o_Err) err_cyc.push_back(cyc);
      for (int k = 0; k < NR; k++) begin
        if (o_Req_Ack[k] && rem[k] > 0) begin
          rem[k]--;
          nxt_byte[k] = nxt_byte[k] + step;
        end
        i_Req_Valid[k]        = (rem[k] != 0) || pulse[k];
        i_Req_Byte[8*k +: 8]  = nxt_byte[k];
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ack_log.delete();
    dv_cyc.delete();
    done_cyc.delete();
    err_cyc.delete();
    dv_byte.delete();
  endtask

  task automatic do_reset();
    i_Reset    = 1'b1;
    i_Req_Lock = '0;
    pulse      = '0;
    step       = 8'd4;
    hang       = 1'b0;
    for (int k = 0; k < NR; k++) begin
      rem[k]      = 0;
      nxt_byte[k] = '0;
    end
    repeat (2) @(posedge i_Clock);
    #1 i_Reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge i_Clock);
      idle = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0) &&
             !o_Busy && !stub_active && (done_cnt == 0);
    end
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 500 && ack_log.size() < n; i++) @(negedge i_Clock);
  endtask

  int exp_id;

  initial begin
    i_Reset    = 1'b1;
    i_Req_Lock = '0;
    pulse      = '0;
    step       = 8'd4;
    for (int k = 0; k < NR; k++) begin
      rem[k]      = 0;
      nxt_byte[k] = '0;
    end

    // Reset state
    @(posedge i_Clock);
    #1;
    check("rst_ack", {28'd0, o_Req_Ack}, 32'd0);
    check("rst_dv", {31'd0, o_Tx_DV}, 32'd0);
    check("rst_byte", {24'd0, o_Tx_Byte}, 32'd0);
    check("rst_busy", {31'd0, o_Busy}, 32'd0);
    check("rst_gid", {30'd0, o_Grant_Id}, 32'd0);
    check("rst_err", {31'd0, o_Err}, 32'd0);

    // Single requester: ack one cycle after valid, DV the cycle after
    do_reset();
    @(posedge i_Clock);
    #1;
    rem[0]      = 1;
    nxt_byte[0] = 8'hA5;
    @(negedge i_Clock);
    check("t1_noack_c0", {28'd0, o_Req_Ack}, 32'd0);
    @(negedge i_Clock);
    check("t1_ack_c1", {28'd0, o_Req_Ack}, 32'd1);
    check("t1_byte", {24'd0, o_Tx_Byte}, 32'hA5);
    check("t1_dv_c1", {31'd0, o_Tx_DV}, 32'd0);
    @(negedge i_Clock);
    check("t1_dv_c2", {31'd0, o_Tx_DV}, 32'd1);
    check("t1_busy", {31'd0, o_Busy}, 32'd1);
    wait_idle("t1_idle");
    check("t1_ndv", dv_cyc.size(), 32'd1);

    // Four requesters, no lock: round-robin 0,1,2,3,0 with 4-clock gaps
    do_reset();
    @(posedge i_Clock);
    #1;
    for (int k = 0; k < NR; k++) begin
      rem[k]      = (k == 0) ? 2 : 1;
      nxt_byte[k] = 8'h10 + 8'(k);
    end
    wait_idle("t2_idle");
    check("t2_nack", ack_log.size(), 32'd5);
    check("t2_ndv", dv_cyc.size(), 32'd5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++) check("t2_order", ack_log[i], i % 4);
    for (int i = 0; i < 5 && i < dv_byte.size(); i++) begin
      check("t2_byte", {24'd0, dv_byte[i]}, 32'h10 + i);
    end
    for (int i = 0; i < 4 && i + 1 < dv_cyc.size() && i < done_cyc.size(); i++) begin
      check("t2_gap", dv_cyc[i+1] - done_cyc[i], 32'd4);
    end

    // Lock: 16 grants to 2, forced rotation to 1, then 2 resumes
    do_reset();
    step       = 8'd1;
    i_Req_Lock = 4'b0100;
    @(posedge i_Clock);
    #1;
    rem[2]      = 20;
    nxt_byte[2] = 8'h40;
    wait_acks(1);
    @(posedge i_Clock);
    #1;
    rem[1]      = 1;
    nxt_byte[1] = 8'h80;
    wait_idle("t3_idle");
    check("t3_nack", ack_log.size(), 32'd21);
    for (int i = 0; i < 21 && i < ack_log.size(); i++) begin
      exp_id = (i == 16) ? 1 : 2;
      check("t3_order", ack_log[i], exp_id);
    end

    // Watchdog: Done never arrives
    do_reset();
    hang = 1'b1;
    @(posedge i_Clock);
    #1;
    rem[0]      = 1;
    nxt_byte[0] = 8'h5A;
    rem[2]      = 1;
    nxt_byte[2] = 8'hC3;
    for (int i = 0; i < 1200 && err_cyc.size() == 0; i++) @(negedge i_Clock);
    check("t4_err_seen", err_cyc.size(), 32'd1);
    if (err_cyc.size() > 0 && dv_cyc.size() > 0) check("t4_err_lat", err_cyc[0] - dv_cyc[0], 32'd1000);
    hang = 1'b0;
    wait_idle("t4_idle");
    check("t4_nerr", err_cyc.size(), 32'd1);
    check("t4_nack", ack_log.size(), 32'd2);
    if (ack_log.size() > 1) check("t4_next", ack_log[1], 32'd2);
    if (dv_byte.size() > 1) check("t4_byte", {24'd0, dv_byte[1]}, 32'hC3);

    // Reset asserted during WAIT_DONE
    do_reset();
    @(posedge i_Clock);
    #1;
    rem[3]      = 1;
    nxt_byte[3] = 8'h33;
    for (int i = 0; i < 100 && dv_cyc.size() == 0; i++) @(negedge i_Clock);
    repeat (5) @(negedge i_Clock);
    check("t5_pre_gid", {30'd0, o_Grant_Id}, 32'd3);
    check("t5_pre_busy", {31'd0, o_Busy}, 32'd1);
    #1 i_Reset = 1'b1;
    #1;
    check("t5_busy", {31'd0, o_Busy}, 32'd0);
    check("t5_gid", {30'd0, o_Grant_Id}, 32'd0);
    check("t5_byte", {24'd0, o_Tx_Byte}, 32'd0);
    rem[0]      = 1;
    nxt_byte[0] = 8'h0A;
    rem[3]      = 1;
    nxt_byte[3] = 8'h3B;
    ack_log.delete();
    @(negedge i_Clock);
    #1 i_Reset = 1'b0;
    wait_acks(1);
    check("t5_nack", {31'd0, ack_log.size() >= 1}, 32'd1);
    if (ack_log.size() > 0) check("t5_first", ack_log[0], 32'd0);
    wait_idle("t5_idle");
    if (ack_log.size() > 1) check("t5_second", ack_log[1], 32'd3);

    // One-cycle valid pulse while busy is ignored
    do_reset();
    @(posedge i_Clock);
    #1;
    rem[0]      = 1;
    nxt_byte[0] = 8'h77;
    wait_acks(1);
    @(posedge i_Clock);
    #1 pulse = 4'b0010;
    @(posedge i_Clock);
    #1 pulse = 4'b0000;
    wait_idle("t6_idle");
    repeat (5) @(negedge i_Clock);
    check("t6_nack", ack_log.size(), 32'd1);
    check("t6_ndv", dv_cyc.size(), 32'd1);
    check("ack_valid_low", viol, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
